// File: rtl/wb_arbiter_pkg.sv
// Shared register-file constants and the writeback request record used by the arbiter.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  wren;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_tag_fifo.sv
// Circular FIFO of load destination tags; responses return in issue order, so the head names the target.
module wb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int W     = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    logic [W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port owner: merges ALU results with in-order load responses and tracks load hazards.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LD_DEPTH = 4,
    parameter int LD_PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_stall,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    output logic                  ld_stall,
    input  logic                  ld_resp_valid,
    input  logic [XLEN-1:0]       ld_resp_data,
    output logic [31:0]           busy_mask,
    output logic                  reg_wren,
    output logic [REG_ADDR_W-1:0] w_reg0,
    output logic [XLEN-1:0]       w_data,
    output logic                  ld_err
);

    logic [31:0]           busy_q, busy_d;
    logic                  ld_err_q, ld_err_d;
    wb_req_t               wr_q, wr_d;

    logic                  fifo_full, fifo_empty;
    logic [LD_PTR_W:0]     fifo_count;
    logic [REG_ADDR_W-1:0] head_rd;
    logic                  ld_acc, ld_pop, alu_acc;

    wb_tag_fifo #(
        .DEPTH (LD_DEPTH),
        .PTR_W (LD_PTR_W),
        .W     (REG_ADDR_W)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (ld_acc),
        .pop_i   (ld_pop),
        .din_i   (ld_rd),
        .dout_o  (head_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Busy check keeps at most one load in flight per register, so set/clear never collide.
    assign ld_stall  = ld_issue & (fifo_full | ((ld_rd != REG_ZERO) & busy_q[ld_rd]));
    assign ld_acc    = ld_issue & ~ld_stall;
    assign ld_pop    = ld_resp_valid & ~fifo_empty;

    // Load data cannot be back-pressured, so it owns the port; busy check preserves WAW order.
    assign alu_stall = alu_valid & (ld_resp_valid | ((alu_rd != REG_ZERO) & busy_q[alu_rd]));
    assign alu_acc   = alu_valid & ~alu_stall;

    always_comb begin
        busy_d   = busy_q;
        ld_err_d = ld_err_q | (ld_resp_valid & fifo_empty);
        wr_d     = wr_q;
        wr_d.wren = 1'b0;
        if (ld_pop) begin
            busy_d[head_rd] = 1'b0;
            if (head_rd != REG_ZERO) begin
                wr_d.wren = 1'b1;
                wr_d.rd   = head_rd;
                wr_d.data = ld_resp_data;
            end
        end else if (alu_acc && alu_rd != REG_ZERO) begin
            wr_d.wren = 1'b1;
            wr_d.rd   = alu_rd;
            wr_d.data = alu_data;
        end
        if (ld_acc && ld_rd != REG_ZERO) busy_d[ld_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            ld_err_q <= 1'b0;
            wr_q     <= '0;
        end else begin
            busy_q   <= busy_d;
            ld_err_q <= ld_err_d;
            wr_q     <= wr_d;
        end
    end

    assign busy_mask = busy_q;
    assign ld_err    = ld_err_q;
    assign reg_wren  = wr_q.wren;
    assign w_reg0    = wr_q.rd;
    assign w_data    = wr_q.data;

    logic unused_ok;
    assign unused_ok = ^fifo_count;

endmodule
